mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Select-sequencing controller for a 4:1 mux: walks ch0..ch3, settles DWELL cycles each,
// captures mux_out per channel and strobes the 4-bit word. Optional macro: MUX_SCAN_CONT_EN.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic [3:0] sample,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t     state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cap_q, cap_d;
  logic [3:0] sample_q, sample_d;
  logic       start_q;
  logic       trig;

`ifdef MUX_SCAN_CONT_EN
  assign trig = start;
`else
  assign trig = start & ~start_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= 2'd0;
      cnt_q    <= 4'd0;
      cap_q    <= 4'd0;
      sample_q <= 4'd0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      sample_q <= sample_d;
      start_q  <= start;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    sample_d = sample_q;
    case (state_q)
      IDLE: begin
        // abort outranks a same-cycle trigger
        if (trig && !abort) begin
          state_d = SETTLE;
          ch_d    = 2'd0;
          cnt_d   = 4'd0;
          cap_d   = 4'd0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          ch_d    = 2'd0;
          cnt_d   = 4'd0;
          cap_d   = 4'd0;
        end else if (cnt_q == DWELL_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          ch_d    = 2'd0;
          cnt_d   = 4'd0;
          cap_d   = 4'd0;
        end else begin
          cap_d[ch_q] = mux_out;
          cnt_d       = 4'd0;
          if (ch_q == 2'd3) begin
            state_d  = DONE;
            sample_d = cap_d;
          end else begin
            state_d = SETTLE;
            ch_d    = ch_q + 2'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        ch_d    = 2'd0;
        cnt_d   = 4'd0;
        cap_d   = 4'd0;
`ifdef MUX_SCAN_CONT_EN
        if (start) state_d = SETTLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode flops only; no input-to-output combinational path.
  assign busy   = (state_q == SETTLE) || (state_q == SAMPLE);
  assign valid  = (state_q == DONE);
  assign s0     = busy & ch_q[1];
  assign s1     = busy & ch_q[0];
  assign sample = sample_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: DWELL=2 and DWELL=1 instances, each with a 4:1 mux model.
module tb_mux_scan_ctrl;
  logic clk, rst, abort;
  logic [1:0] start_v;
  logic [1:0][3:0] mux_in;
  logic [1:0] s0_v, s1_v, valid_v, busy_v, mout_v;
  logic [1:0][3:0] sample_v;
  logic [1:0][3:0] obs;
  int total, bad;

  mux_scan_ctrl #(.DWELL(2)) u_dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort), .mux_out(mout_v[0]),
    .s0(s0_v[0]), .s1(s1_v[0]), .sample(sample_v[0]), .valid(valid_v[0]), .busy(busy_v[0]));

  mux_scan_ctrl #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(1'b0), .mux_out(mout_v[1]),
    .s0(s0_v[1]), .s1(s1_v[1]), .sample(sample_v[1]), .valid(valid_v[1]), .busy(busy_v[1]));

  assign mout_v[0] = mux_in[0][{s0_v[0], s1_v[0]}];
  assign mout_v[1] = mux_in[1][{s0_v[1], s1_v[1]}];
  assign obs[0] = {busy_v[0], valid_v[0], s0_v[0], s1_v[0]};
  assign obs[1] = {busy_v[1], valid_v[1], s0_v[1], s1_v[1]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One start pulse, then cycle-by-cycle check of {busy,valid,s0,s1} through DONE.
  task automatic scan(input int d, input int dw, input logic [3:0] exp_word);
    int last;
    logic [3:0] e;
    last = 4 * (dw + 1);
    start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
    for (int i = 1; i <= last + 1; i++) begin
      if (i <= last) e = {2'b10, 2'((i - 1) / (dw + 1))};
      else           e = 4'b0100;
      chk($sformatf("scan%0d_cyc%0d", d, i), 32'(obs[d]), 32'(e));
      if (i == last + 1) chk($sformatf("scan%0d_word", d), 32'(sample_v[d]), 32'(exp_word));
      step();
    end
    chk($sformatf("scan%0d_after", d), 32'({obs[d], sample_v[d]}), 32'({4'b0000, exp_word}));
  endtask

  initial begin
    int vcnt, vfirst, vsecond;
    logic seen;
    total = 0; bad = 0;
    rst = 1'b1; abort = 1'b0; start_v = '0;
    mux_in[0] = 4'b1101; mux_in[1] = 4'b1111;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_obs", 32'(obs[0]), 32'h0);
    chk("reset_sample", 32'(sample_v[0]), 32'h0);

    // single scan: a=1 b=0 c=1 d=1
    scan(0, 2, 4'b1101);

    // abort in cycle k+5 (ch1 settle)
    mux_in[0] = 4'b0000;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    repeat (4) step();
    chk("abort_pre_busy", 32'(obs[0]), 32'b1001);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", 32'(obs[0]), 32'h0);
    chk("abort_sample_kept", 32'(sample_v[0]), 32'hd);
    seen = 1'b0;
    repeat (14) begin step(); if (valid_v[0] || busy_v[0]) seen = 1'b1; end
    chk("abort_no_valid", 32'(seen), 32'h0);

    // start and abort together in IDLE
    start_v[0] = 1'b1; abort = 1'b1;
    step();
    start_v[0] = 1'b0; abort = 1'b0;
    chk("st_ab_busy", 32'(busy_v[0]), 32'h0);
    seen = 1'b0;
    repeat (5) begin step(); if (busy_v[0]) seen = 1'b1; end
    chk("st_ab_stay_idle", 32'(seen), 32'h0);

    // start held for 40 cycles
    mux_in[0] = 4'b1101;
    vcnt = 0; vfirst = 0; vsecond = 0;
    start_v[0] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (valid_v[0]) begin
        vcnt++;
        if (vcnt == 1) vfirst = i;
        if (vcnt == 2) vsecond = i;
      end
    end
    start_v[0] = 1'b0;
    chk("held_first", 32'(vfirst), 32'd13);
`ifdef MUX_SCAN_CONT_EN
    chk("held_count", 32'(vcnt), 32'd3);
    chk("held_second", 32'(vsecond), 32'd26);
`else
    chk("held_count", 32'(vcnt), 32'd1);
`endif
    chk("held_sample", 32'(sample_v[0]), 32'hd);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("held_cleanup", 32'(obs[0]), 32'h0);

    // reset mid-scan clears sample
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    repeat (4) step();
    chk("rst_pre_busy", 32'(busy_v[0]), 32'h1);
    rst = 1'b1;
    step();
    chk("rst_obs", 32'(obs[0]), 32'h0);
    chk("rst_sample", 32'(sample_v[0]), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("rst_after_obs", 32'({obs[0], sample_v[0]}), 32'h0);
    seen = 1'b0;
    repeat (15) begin step(); if (valid_v[0] || busy_v[0]) seen = 1'b1; end
    chk("rst_no_resume", 32'(seen), 32'h0);

    // DWELL=1, a changes 1 -> 0 between scans
    scan(1, 1, 4'b1111);
    mux_in[1] = 4'b1110;
    step();
    scan(1, 1, 4'b1110);
    chk("dw1_bit0", 32'(sample_v[1][0]), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
